// File: rtl/sdram_pkg.sv
// Shared types and widths for the SDRAM Avalon-MM responder and the master side in rf_ldst.
package sdram_pkg;

    localparam int SDRAM_DATA_W  = 128;
    localparam int SDRAM_ADDR_W  = 24;
    localparam int SDRAM_BURST_W = 4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WR_BURST = 2'd1,
        RD_BURST = 2'd2
    } sdram_resp_state_t;

endpackage

// File: rtl/sdram_resp_mem.sv
// Single-port synchronous backing store: one-cycle registered read, per-byte write enable.
module sdram_resp_mem #(
    parameter int AW = 12,
    parameter int DW = 128
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic            we,
    input  logic [AW-1:0]   addr,
    input  logic [DW-1:0]   wdata,
    input  logic [DW/8-1:0] be,
    output logic [DW-1:0]   rdata
);

    logic [DW-1:0] mem [2**AW];

    // NOTE: the array has no reset branch on purpose; contents survive rst_n and a
    // reset loop over every word would stop this mapping onto block RAM.
    always_ff @(posedge clk) begin
        if (en && we) begin
            for (int b = 0; b < DW/8; b++) begin
                if (be[b]) mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
    end

    // Output register only moves on a read, so it doubles as the hold register.
    always_ff @(posedge clk) begin
        if (!rst_n)         rdata <= '0;
        else if (en && !we) rdata <= mem[addr];
    end

endmodule

// File: rtl/sdram_avmm_responder.sv
// Avalon-MM SDRAM stand-in: byte-enabled on-chip store, bursts, fixed read latency.
// Optional random waitrequest stalls when SDRAM_RESP_STALL_EN is defined.
module sdram_avmm_responder
    import sdram_pkg::*;
#(
    parameter int ADDR_W     = SDRAM_ADDR_W,
    parameter int DATA_W     = SDRAM_DATA_W,
    parameter int MEM_AW     = 12,
    parameter int BURST_W    = SDRAM_BURST_W,
    parameter int RD_LATENCY = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [ADDR_W-1:0]   address,
    input  logic                read,
    input  logic                write,
    input  logic [BURST_W-1:0]  burstcount,
    input  logic [DATA_W-1:0]   writedata,
    input  logic [DATA_W/8-1:0] byteenable,
    output logic                waitrequest,
    output logic [DATA_W-1:0]   readdata,
    output logic                readdatavalid,
    output logic                protocol_err
);

    sdram_resp_state_t   state_q, state_d;
    logic [MEM_AW-1:0]   addr_q, addr_d;
    logic [BURST_W-1:0]  remain_q, remain_d;
    logic                err_q, err_d;
    logic                mem_en, mem_we, issue;
    logic [MEM_AW-1:0]   mem_addr;
    logic [DATA_W-1:0]   ram_q;
    logic [RD_LATENCY-1:0] vld;
    logic                stall, hold;
    logic                unused_addr_bits;

    assign unused_addr_bits = ^address[ADDR_W-1:MEM_AW];

`ifdef SDRAM_RESP_STALL_EN
    logic [15:0] lfsr_q;

    always_ff @(posedge clk) begin
        if (!rst_n) lfsr_q <= 16'hACE1;
        else        lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end

    assign stall = (lfsr_q[1:0] == 2'b00);
`else
    assign stall = 1'b0;
`endif

    // Nothing is accepted or issued while in reset, so memory is untouched by rst_n.
    assign hold = stall || !rst_n;

    // NOTE: every signal gets its default before the case, so no path leaves one
    // unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remain_d    = remain_q;
        err_d       = err_q;
        mem_en      = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = addr_q;
        issue       = 1'b0;
        waitrequest = hold;
        case (state_q)
            IDLE: begin
                if ((read || write) && !hold) begin
                    if (write) begin
                        mem_en   = 1'b1;
                        mem_we   = 1'b1;
                        mem_addr = address[MEM_AW-1:0];
                        addr_d   = address[MEM_AW-1:0] + MEM_AW'(1);
                        if (burstcount > BURST_W'(1)) begin
                            state_d  = WR_BURST;
                            remain_d = burstcount - BURST_W'(1);
                        end
                    end else begin
                        state_d  = RD_BURST;
                        addr_d   = address[MEM_AW-1:0];
                        remain_d = (burstcount == '0) ? BURST_W'(1) : burstcount;
                    end
                    if ((read && write) || burstcount == '0) err_d = 1'b1;
                end
            end
            WR_BURST: begin
                if (write && !hold) begin
                    mem_en   = 1'b1;
                    mem_we   = 1'b1;
                    addr_d   = addr_q + MEM_AW'(1);
                    remain_d = remain_q - BURST_W'(1);
                    if (remain_q == BURST_W'(1)) state_d = IDLE;
                end
            end
            RD_BURST: begin
                waitrequest = 1'b1;
                if (!hold) begin
                    mem_en   = 1'b1;
                    issue    = 1'b1;
                    addr_d   = addr_q + MEM_AW'(1);
                    remain_d = remain_q - BURST_W'(1);
                    if (remain_q == BURST_W'(1)) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            remain_q <= '0;
            err_q    <= 1'b0;
            vld      <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            remain_q <= remain_d;
            err_q    <= err_d;
            vld[0]   <= issue;
            for (int i = 1; i < RD_LATENCY; i++) vld[i] <= vld[i-1];
        end
    end

    sdram_resp_mem #(.AW(MEM_AW), .DW(DATA_W)) u_mem (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (mem_en),
        .we    (mem_we),
        .addr  (mem_addr),
        .wdata (writedata),
        .be    (byteenable),
        .rdata (ram_q)
    );

    // RAM output is stage 1; the remaining stages advance only with their valid bit.
    if (RD_LATENCY > 1) begin : g_pipe
        logic [DATA_W-1:0] dat [1:RD_LATENCY-1];

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                for (int i = 1; i < RD_LATENCY; i++) dat[i] <= '0;
            end else begin
                if (vld[0]) dat[1] <= ram_q;
                for (int i = 2; i < RD_LATENCY; i++) begin
                    if (vld[i-1]) dat[i] <= dat[i-1];
                end
            end
        end

        assign readdata = dat[RD_LATENCY-1];
    end else begin : g_nopipe
        assign readdata = ram_q;
    end

    assign readdatavalid = vld[RD_LATENCY-1];
    assign protocol_err  = err_q;

endmodule

// File: tb/tb_sdram_avmm_responder.sv
// Self-checking bench for sdram_avmm_responder: directed scenarios plus randomized
// bursts compared against a flat-array memory model with latency expectations.
module tb_sdram_avmm_responder;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [23:0]  address = '0;
    logic         read = 1'b0;
    logic         write = 1'b0;
    logic [3:0]   burstcount = '0;
    logic [127:0] writedata = '0;
    logic [15:0]  byteenable = '0;
    logic         waitrequest;
    logic [127:0] readdata;
    logic         readdatavalid;
    logic         protocol_err;

    localparam int LAT = 3;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [127:0] mdl [4096];
    logic [127:0] wd  [16];
    logic [15:0]  wbe [16];
    logic [127:0] exp_d [16];
    logic [127:0] got_q [$];
    int           gcyc_q [$];

    sdram_avmm_responder dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .address       (address),
        .read          (read),
        .write         (write),
        .burstcount    (burstcount),
        .writedata     (writedata),
        .byteenable    (byteenable),
        .waitrequest   (waitrequest),
        .readdata      (readdata),
        .readdatavalid (readdatavalid),
        .protocol_err  (protocol_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        if (readdatavalid === 1'b1) begin
            got_q.push_back(readdata);
            gcyc_q.push_back(cyc);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic void model_write(input int ma, input logic [127:0] d, input logic [15:0] be);
        for (int b = 0; b < 16; b++) begin
            if (be[b]) mdl[ma][b*8 +: 8] = d[b*8 +: 8];
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_accept(input string what);
        int t = 0;
        while (waitrequest !== 1'b0 && t < 50) begin
            tick();
            t++;
        end
        checks++;
        if (waitrequest !== 1'b0) begin
            errors++;
            $display("FAIL %s: waitrequest=%b after %0d cycles, required 0", what, waitrequest, t);
        end
        tick();
    endtask

    task automatic wr_burst(input logic [23:0] a, input int n, input int gap_at, output int acc0);
        acc0 = 0;
        for (int i = 0; i < n; i++) begin
            if (i == gap_at) begin
                write   = 1'b0;
                address = 24'($urandom);
                tick();
            end
            address    = (i == 0) ? a : 24'($urandom);
            burstcount = (i == 0) ? 4'(n) : 4'($urandom);
            writedata  = wd[i];
            byteenable = wbe[i];
            write      = 1'b1;
            wait_accept("wr_accept");
            if (i == 0) acc0 = cyc;
            model_write((int'(a[11:0]) + i) % 4096, wd[i], wbe[i]);
        end
        write = 1'b0;
    endtask

    task automatic rd_cmd(input logic [23:0] a, input int bc, output int acc);
        got_q.delete();
        gcyc_q.delete();
        address    = a;
        burstcount = 4'(bc);
        read       = 1'b1;
        wait_accept("rd_accept");
        acc     = cyc;
        read    = 1'b0;
        address = 24'($urandom);
    endtask

    task automatic wait_beats(input int n);
        int t = 0;
        while (got_q.size() < n && t < n + 20) begin
            tick();
            t++;
        end
        tick();
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        checks += 4;
        if (waitrequest !== 1'b1) begin errors++; $display("FAIL reset_wait: got %b exp 1", waitrequest); end
        if (readdatavalid !== 1'b0) begin errors++; $display("FAIL reset_rdv: got %b exp 0", readdatavalid); end
        if (readdata !== '0) begin errors++; $display("FAIL reset_rdata: got %h exp 0", readdata); end
        if (protocol_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b exp 0", protocol_err); end
        rst_n = 1'b1;
        tick();
        checks++;
        if (waitrequest !== 1'b0) begin errors++; $display("FAIL idle_wait: got %b exp 0", waitrequest); end
    endtask

    task automatic test_single();
        int acc, a0;
        wd[0]  = {16{8'hA5}};
        wbe[0] = '1;
        wr_burst(24'h10, 1, -1, a0);
        rd_cmd(24'h10, 1, acc);
        wait_beats(1);
        checks += 5;
        if (got_q.size() != 1) begin errors++; $display("FAIL single_count: got %0d exp 1", got_q.size()); end
        if (got_q.size() > 0 && got_q[0] !== {16{8'hA5}}) begin errors++; $display("FAIL single_data: got %h exp %h", got_q[0], {16{8'hA5}}); end
        if (gcyc_q.size() > 0 && gcyc_q[0] != acc + LAT) begin errors++; $display("FAIL single_lat: got %0d exp %0d", gcyc_q[0] - acc, LAT); end
        if (readdatavalid !== 1'b0) begin errors++; $display("FAIL single_rdv_low: got %b exp 0", readdatavalid); end
        if (readdata !== {16{8'hA5}}) begin errors++; $display("FAIL single_hold: got %h exp %h", readdata, {16{8'hA5}}); end
    endtask

    task automatic test_burst_gap();
        int acc, a0;
        for (int i = 0; i < 4; i++) begin
            wd[i]  = 128'(i + 1);
            wbe[i] = '1;
        end
        wr_burst(24'h20, 4, 2, a0);
        rd_cmd(24'h20, 4, acc);
        checks++;
        if (waitrequest !== 1'b1) begin errors++; $display("FAIL rdburst_wait: got %b exp 1", waitrequest); end
        wait_beats(4);
        checks++;
        if (got_q.size() != 4) begin errors++; $display("FAIL burst_count: got %0d exp 4", got_q.size()); end
        for (int i = 0; i < 4 && i < got_q.size(); i++) begin
            checks += 2;
            if (got_q[i] !== 128'(i + 1)) begin errors++; $display("FAIL burst_data[%0d]: got %h exp %h", i, got_q[i], 128'(i + 1)); end
            if (gcyc_q[i] != acc + LAT + i) begin errors++; $display("FAIL burst_cycle[%0d]: got %0d exp %0d", i, gcyc_q[i] - acc, LAT + i); end
        end
    endtask

    task automatic test_byteenable();
        int acc, a0;
        logic [127:0] e;
        e = {{8{8'hFF}}, {8{8'h00}}};
        wd[0] = '1; wbe[0] = '1;
        wr_burst(24'h30, 1, -1, a0);
        wd[0] = '0; wbe[0] = 16'h00FF;
        wr_burst(24'h30, 1, -1, a0);
        rd_cmd(24'h30, 1, acc);
        wait_beats(1);
        checks += 2;
        if (got_q.size() != 1) begin errors++; $display("FAIL be_count: got %0d exp 1", got_q.size()); end
        if (got_q.size() > 0 && got_q[0] !== e) begin errors++; $display("FAIL be_data: got %h exp %h", got_q[0], e); end
    endtask

    task automatic test_wrap();
        int acc, a0;
        for (int i = 0; i < 3; i++) begin
            wd[i]  = rand128();
            wbe[i] = '1;
        end
        wr_burst(24'h000FFF, 3, -1, a0);
        rd_cmd(24'h7F0FFF, 3, acc);
        wait_beats(3);
        checks++;
        if (got_q.size() != 3) begin errors++; $display("FAIL wrap_count: got %0d exp 3", got_q.size()); end
        for (int i = 0; i < 3 && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== wd[i]) begin errors++; $display("FAIL wrap_data[%0d]: got %h exp %h", i, got_q[i], wd[i]); end
        end
        rd_cmd(24'h000001, 1, acc);
        wait_beats(1);
        checks++;
        if (got_q.size() < 1 || got_q[0] !== wd[2]) begin errors++; $display("FAIL wrap_land: got %h exp %h", (got_q.size() > 0) ? got_q[0] : 'x, wd[2]); end
    endtask

    task automatic test_back_to_back();
        int acc, a0;
        for (int i = 0; i < 2; i++) begin
            wd[i]  = rand128();
            wbe[i] = '1;
        end
        wr_burst(24'h50, 2, -1, a0);
        exp_d[0] = mdl[12'h50];
        exp_d[1] = mdl[12'h51];
        rd_cmd(24'h50, 2, acc);
        for (int i = 0; i < 2; i++) begin
            wd[i]  = rand128();
            wbe[i] = '1;
        end
        wr_burst(24'h50, 2, -1, a0);
        wait_beats(2);
        checks += 2;
        if (a0 != acc + 3) begin errors++; $display("FAIL b2b_accept: got %0d exp %0d", a0 - acc, 3); end
        if (got_q.size() != 2) begin errors++; $display("FAIL rbw_count: got %0d exp 2", got_q.size()); end
        for (int i = 0; i < 2 && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_d[i]) begin errors++; $display("FAIL rbw_data[%0d]: got %h exp %h", i, got_q[i], exp_d[i]); end
        end
        rd_cmd(24'h50, 2, acc);
        wait_beats(2);
        for (int i = 0; i < 2 && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== wd[i]) begin errors++; $display("FAIL rbw_new[%0d]: got %h exp %h", i, got_q[i], wd[i]); end
        end
    endtask

    task automatic test_random();
        int acc, a0, n;
        logic [11:0] base;
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 15; i++) begin
                wd[i]  = rand128();
                wbe[i] = '1;
            end
            wr_burst(24'h100 + 24'(15 * k), 15, -1, a0);
        end
        for (int op = 0; op < 24; op++) begin
            n    = $urandom_range(1, 8);
            base = 12'h100 + 12'($urandom_range(0, 60 - n));
            if ($urandom_range(0, 1) == 1) begin
                for (int i = 0; i < n; i++) begin
                    wd[i]  = rand128();
                    wbe[i] = 16'($urandom);
                end
                wr_burst({12'($urandom), base}, n, $urandom_range(0, n), a0);
            end else begin
                for (int i = 0; i < n; i++) exp_d[i] = mdl[(int'(base) + i) % 4096];
                rd_cmd({12'($urandom), base}, n, acc);
                wait_beats(n);
                checks++;
                if (got_q.size() != n) begin errors++; $display("FAIL rnd_count op%0d: got %0d exp %0d", op, got_q.size(), n); end
                for (int i = 0; i < n && i < got_q.size(); i++) begin
                    checks += 2;
                    if (got_q[i] !== exp_d[i]) begin errors++; $display("FAIL rnd_data op%0d[%0d]: got %h exp %h", op, i, got_q[i], exp_d[i]); end
                    if (gcyc_q[i] != acc + LAT + i) begin errors++; $display("FAIL rnd_cycle op%0d[%0d]: got %0d exp %0d", op, i, gcyc_q[i] - acc, LAT + i); end
                end
            end
        end
    endtask

    task automatic test_protocol();
        int acc;
        logic [127:0] d;
        checks++;
        if (protocol_err !== 1'b0) begin errors++; $display("FAIL err_clean: got %b exp 0", protocol_err); end
        got_q.delete();
        d          = rand128();
        address    = 24'h60;
        burstcount = 4'd1;
        writedata  = d;
        byteenable = '1;
        read       = 1'b1;
        write      = 1'b1;
        wait_accept("rw_accept");
        read  = 1'b0;
        write = 1'b0;
        model_write(12'h60, d, 16'hFFFF);
        repeat (6) tick();
        checks += 2;
        if (protocol_err !== 1'b1) begin errors++; $display("FAIL err_rw: got %b exp 1", protocol_err); end
        if (got_q.size() != 0) begin errors++; $display("FAIL rw_noread: got %0d beats exp 0", got_q.size()); end
        rd_cmd(24'h60, 0, acc);
        wait_beats(1);
        checks += 3;
        if (got_q.size() != 1) begin errors++; $display("FAIL bc0_count: got %0d exp 1", got_q.size()); end
        if (got_q.size() > 0 && got_q[0] !== d) begin errors++; $display("FAIL bc0_data: got %h exp %h", got_q[0], d); end
        if (protocol_err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b exp 1", protocol_err); end
    endtask

    task automatic test_reset_mid_burst();
        int acc;
        rd_cmd(24'h100, 8, acc);
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        checks++;
        if (waitrequest !== 1'b1) begin errors++; $display("FAIL rst_wait: got %b exp 1", waitrequest); end
        got_q.delete();
        tick();
        checks++;
        if (readdatavalid !== 1'b0) begin errors++; $display("FAIL rst_rdv: got %b exp 0", readdatavalid); end
        tick();
        rst_n = 1'b1;
        repeat (12) tick();
        checks += 4;
        if (got_q.size() != 0) begin errors++; $display("FAIL rst_drain: got %0d beats exp 0", got_q.size()); end
        if (waitrequest !== 1'b0) begin errors++; $display("FAIL rst_idle: got %b exp 0", waitrequest); end
        if (protocol_err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b exp 0", protocol_err); end
        rd_cmd(24'h20, 1, acc);
        wait_beats(1);
        if (got_q.size() < 1 || got_q[0] !== 128'd1) begin errors++; $display("FAIL retain: got %h exp %h", (got_q.size() > 0) ? got_q[0] : 'x, 128'd1); end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mdl[i] = '0;
        test_reset();
        test_single();
        test_burst_gap();
        test_byteenable();
        test_wrap();
        test_back_to_back();
        test_random();
        test_protocol();
        test_reset_mid_burst();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
